otter_line_arbiter: RTL and testbench

//  Arbitrates the OTTER data memory port between the I-cache line-fill requester (IC) and the D-cache

---
 rtl/otter_line_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_otter_line_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_line_arbiter.sv
// ---------------------------------------------------------------------------
// otter_line_arbiter
//
// Purpose:
//   Shares the OTTER data-memory line port between the I-cache line-fill
//   requester (IC) and the D-cache requester (DC, fills and write-backs).
//   One 16-byte line transfer is in flight at a time. Every output is
//   registered and is computed from the next FSM state.
//
// Build option:
//   OTTER_ARB_RR_EN  defined   -> round-robin arbitration. The pointer moves
//                                 to the other requester after every grant
//                                 (error responses included). On a tie the
//                                 side the pointer names wins.
//                    undefined -> fixed priority, DC wins every tie.
//
// Parameters:
//   ACTUAL_WIDTH  memory word-address width; a line address is legal when it
//                 is below 2**(ACTUAL_WIDTH+2) and below 32'h1100_0000
//   RD_LAT        memory read latency in cycles, 1..7
//
// Ports:
//   MEM_CLK, MEM_RST_N         clock, synchronous active-low reset
//   IC_REQ/IC_ADDR             IC line-read request (held until IC_ACK)
//   IC_ACK/IC_ERR/IC_LINE      IC completion pulse, range error, read line
//   DC_REQ/DC_WE/DC_ADDR       DC request, 1 = write-back, byte address
//   DC_WLINE                   DC write-back line {w3,w2,w1,w0}
//   DC_ACK/DC_ERR/DC_RLINE     DC completion pulse, range error, read line
//   MEM_ADDR2                  line base byte address to memory
//   MEM_READ2/MEM_WRITE2       one-cycle read / write strobes
//   MEM_w0..3                  write-back words, w0 at the lowest address
//   MEM_r0..3                  read words, valid RD_LAT cycles after MEM_READ2
// ---------------------------------------------------------------------------
module otter_line_arbiter #(
  parameter int ACTUAL_WIDTH = 14,
  parameter int RD_LAT       = 1
) (
  input  logic         MEM_CLK,
  input  logic         MEM_RST_N,
  input  logic         IC_REQ,
  input  logic [31:0]  IC_ADDR,
  output logic         IC_ACK,
  output logic         IC_ERR,
  output logic [127:0] IC_LINE,
  input  logic         DC_REQ,
  input  logic         DC_WE,
  input  logic [31:0]  DC_ADDR,
  input  logic [127:0] DC_WLINE,
  output logic         DC_ACK,
  output logic         DC_ERR,
  output logic [127:0] DC_RLINE,
  output logic [31:0]  MEM_ADDR2,
  output logic         MEM_READ2,
  output logic         MEM_WRITE2,
  output logic [31:0]  MEM_w0,
  output logic [31:0]  MEM_w1,
  output logic [31:0]  MEM_w2,
  output logic [31:0]  MEM_w3,
  input  logic [31:0]  MEM_r0,
  input  logic [31:0]  MEM_r1,
  input  logic [31:0]  MEM_r2,
  input  logic [31:0]  MEM_r3
);

  // Limit kept in 64 bits so large ACTUAL_WIDTH values cannot overflow.
  localparam logic [63:0] LINE_LIMIT = 64'd1 << (ACTUAL_WIDTH + 2);
  localparam logic [31:0] IO_BASE    = 32'h1100_0000;
  // WAIT is entered with RD_LAT-1 and leaves when the count reaches zero,
  // so WAIT lasts exactly RD_LAT cycles.
  localparam logic [2:0]  WAIT_LOAD  = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_RESP,
    S_WR,
    S_ERR
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic           r_owner_dc;     // 1 = current transfer belongs to DC
  logic [2:0]     r_wait_cnt;
  logic           r_ic_ack;
  logic           r_ic_err;
  logic [127:0]   r_ic_line;
  logic           r_dc_ack;
  logic           r_dc_err;
  logic [127:0]   r_dc_rline;
  logic [31:0]    r_mem_addr;
  logic           r_mem_read2;
  logic           r_mem_write2;
  logic [127:0]   r_mem_wline;

`ifdef OTTER_ARB_RR_EN
  logic           r_rr_ic;        // 1 = pointer on IC, 0 = pointer on DC
`endif

  logic           w_any_req;
  logic           w_grant_dc;
  logic [31:0]    w_gnt_addr;
  logic           w_gnt_we;
  logic           w_gnt_err;
  logic           w_owner_dc;
  logic           w_ack;
  logic           w_err;

  function automatic logic f_out_of_range(input logic [31:0] addr);
    return ({32'd0, addr} >= LINE_LIMIT) || (addr >= IO_BASE);
  endfunction

  // -------------------------------------------------------------------------
  // Arbitration and next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_any_req    = IC_REQ | DC_REQ;

`ifdef OTTER_ARB_RR_EN
    if (IC_REQ && DC_REQ) begin
      w_grant_dc = ~r_rr_ic;
    end else begin
      w_grant_dc = DC_REQ;
    end
`else
    w_grant_dc = DC_REQ;
`endif

    w_gnt_addr = w_grant_dc ? DC_ADDR : IC_ADDR;
    // IC never writes; DC_WE only counts when DC holds the grant.
    w_gnt_we   = w_grant_dc & DC_WE;
    w_gnt_err  = f_out_of_range(w_gnt_addr);

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          if (w_gnt_err) begin
            w_state_next = S_ERR;
          end else if (w_gnt_we) begin
            w_state_next = S_WR;
          end else begin
            w_state_next = S_RD;
          end
        end
      end
      S_RD:    w_state_next = S_WAIT;
      S_WAIT:  w_state_next = (r_wait_cnt == 3'd0) ? S_RESP : S_WAIT;
      S_WR:    w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // In IDLE the owner is being decided this very cycle; error responses
    // are issued on the next cycle, so the fresh grant must steer ACK/ERR.
    w_owner_dc = (r_state == S_IDLE) ? w_grant_dc : r_owner_dc;
    w_ack      = (w_state_next == S_RESP) || (w_state_next == S_ERR);
    w_err      = (w_state_next == S_ERR);
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge MEM_CLK) begin
    if (!MEM_RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs and transfer context
  // -------------------------------------------------------------------------
  always_ff @(posedge MEM_CLK) begin
    if (!MEM_RST_N) begin
      r_owner_dc   <= 1'b0;
      r_wait_cnt   <= 3'd0;
      r_ic_ack     <= 1'b0;
      r_ic_err     <= 1'b0;
      r_ic_line    <= '0;
      r_dc_ack     <= 1'b0;
      r_dc_err     <= 1'b0;
      r_dc_rline   <= '0;
      r_mem_addr   <= '0;
      r_mem_read2  <= 1'b0;
      r_mem_write2 <= 1'b0;
      r_mem_wline  <= '0;
    end else begin
      r_mem_read2  <= (w_state_next == S_RD);
      r_mem_write2 <= (w_state_next == S_WR);
      r_ic_ack     <= w_ack & ~w_owner_dc;
      r_dc_ack     <= w_ack &  w_owner_dc;
      r_ic_err     <= w_err & ~w_owner_dc;
      r_dc_err     <= w_err &  w_owner_dc;

      if ((r_state == S_IDLE) && w_any_req) begin
        r_owner_dc <= w_grant_dc;
        // Error responses leave MEM_ADDR2 on the last real line address.
        if (!w_gnt_err) begin
          r_mem_addr <= {w_gnt_addr[31:4], 4'b0000};
        end
        if (!w_gnt_err && w_gnt_we) begin
          r_mem_wline <= DC_WLINE;
        end
      end

      if (r_state == S_RD) begin
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end

      // Read data is only valid on the final WAIT cycle.
      if ((r_state == S_WAIT) && (r_wait_cnt == 3'd0)) begin
        if (r_owner_dc) begin
          r_dc_rline <= {MEM_r3, MEM_r2, MEM_r1, MEM_r0};
        end else begin
          r_ic_line  <= {MEM_r3, MEM_r2, MEM_r1, MEM_r0};
        end
      end
    end
  end

`ifdef OTTER_ARB_RR_EN
  // Pointer moves away from whoever was just granted.
  always_ff @(posedge MEM_CLK) begin
    if (!MEM_RST_N) begin
      r_rr_ic <= 1'b1;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_rr_ic <= w_grant_dc;
    end
  end
`endif

  assign IC_ACK     = r_ic_ack;
  assign IC_ERR     = r_ic_err;
  assign IC_LINE    = r_ic_line;
  assign DC_ACK     = r_dc_ack;
  assign DC_ERR     = r_dc_err;
  assign DC_RLINE   = r_dc_rline;
  assign MEM_ADDR2  = r_mem_addr;
  assign MEM_READ2  = r_mem_read2;
  assign MEM_WRITE2 = r_mem_write2;
  assign MEM_w0     = r_mem_wline[31:0];
  assign MEM_w1     = r_mem_wline[63:32];
  assign MEM_w2     = r_mem_wline[95:64];
  assign MEM_w3     = r_mem_wline[127:96];

endmodule

// File: tb/tb_otter_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_otter_line_arbiter
//
// Directed bench for otter_line_arbiter. dut1 runs with RD_LAT=1 and dut3
// with RD_LAT=3; both share one behavioural line memory. The memory drives
// MEM_r0..3 with real data only on the single cycle the data is defined and
// with a filler pattern otherwise. Works with or without OTTER_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_otter_line_arbiter;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  localparam logic [127:0] LINE_100 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] LINE_200 = {32'hDDDD_0004, 32'hCCCC_0003,
                                       32'hBBBB_0002, 32'hAAAA_0001};

  logic clk = 1'b0;
  logic rst_n;
  logic mem_init;

  always #5 clk = ~clk;

  // dut1 signals
  logic         ic_req, dc_req, dc_we;
  logic [31:0]  ic_addr, dc_addr;
  logic [127:0] dc_wline;
  logic         ic_ack, ic_err, dc_ack, dc_err;
  logic [127:0] ic_line, dc_rline;
  logic [31:0]  mem_addr2, mem_w0, mem_w1, mem_w2, mem_w3;
  logic         mem_read2, mem_write2;
  logic [31:0]  mem_r0, mem_r1, mem_r2, mem_r3;

  // dut3 signals
  logic         ic_req3, dc_req3, dc_we3;
  logic [31:0]  ic_addr3, dc_addr3;
  logic [127:0] dc_wline3;
  logic         ic_ack3, ic_err3, dc_ack3, dc_err3;
  logic [127:0] ic_line3, dc_rline3;
  logic [31:0]  mem_addr2_3, mem_w0_3, mem_w1_3, mem_w2_3, mem_w3_3;
  logic         mem_read2_3, mem_write2_3;
  logic [31:0]  mem_r0_3, mem_r1_3, mem_r2_3, mem_r3_3;

  int n_checks = 0;
  int n_errors = 0;

  otter_line_arbiter #(.ACTUAL_WIDTH(14), .RD_LAT(LAT1)) dut1 (
    .MEM_CLK(clk), .MEM_RST_N(rst_n),
    .IC_REQ(ic_req), .IC_ADDR(ic_addr), .IC_ACK(ic_ack), .IC_ERR(ic_err),
    .IC_LINE(ic_line),
    .DC_REQ(dc_req), .DC_WE(dc_we), .DC_ADDR(dc_addr), .DC_WLINE(dc_wline),
    .DC_ACK(dc_ack), .DC_ERR(dc_err), .DC_RLINE(dc_rline),
    .MEM_ADDR2(mem_addr2), .MEM_READ2(mem_read2), .MEM_WRITE2(mem_write2),
    .MEM_w0(mem_w0), .MEM_w1(mem_w1), .MEM_w2(mem_w2), .MEM_w3(mem_w3),
    .MEM_r0(mem_r0), .MEM_r1(mem_r1), .MEM_r2(mem_r2), .MEM_r3(mem_r3)
  );

  otter_line_arbiter #(.ACTUAL_WIDTH(14), .RD_LAT(LAT3)) dut3 (
    .MEM_CLK(clk), .MEM_RST_N(rst_n),
    .IC_REQ(ic_req3), .IC_ADDR(ic_addr3), .IC_ACK(ic_ack3), .IC_ERR(ic_err3),
    .IC_LINE(ic_line3),
    .DC_REQ(dc_req3), .DC_WE(dc_we3), .DC_ADDR(dc_addr3), .DC_WLINE(dc_wline3),
    .DC_ACK(dc_ack3), .DC_ERR(dc_err3), .DC_RLINE(dc_rline3),
    .MEM_ADDR2(mem_addr2_3), .MEM_READ2(mem_read2_3), .MEM_WRITE2(mem_write2_3),
    .MEM_w0(mem_w0_3), .MEM_w1(mem_w1_3), .MEM_w2(mem_w2_3), .MEM_w3(mem_w3_3),
    .MEM_r0(mem_r0_3), .MEM_r1(mem_r1_3), .MEM_r2(mem_r2_3), .MEM_r3(mem_r3_3)
  );

  // ------------------------------------------------------------------------
  // Line memory: 64 lines indexed by address bits [9:4]. Read pipelines
  // record the address on the MEM_READ2 edge; stage LAT-1 marks the one
  // cycle where MEM_r0..3 carry the line.
  // ------------------------------------------------------------------------
  logic [127:0] mem [64];
  logic [7:0]   p1_v, p3_v;
  logic [5:0]   p1_a [8];
  logic [5:0]   p3_a [8];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) mem[k] <= 128'h0;
      mem[16] <= LINE_100;
      p1_v <= 8'd0;
      p3_v <= 8'd0;
    end else begin
      if (mem_write2) mem[mem_addr2[9:4]] <= {mem_w3, mem_w2, mem_w1, mem_w0};
      p1_v <= {p1_v[6:0], mem_read2};
      p3_v <= {p3_v[6:0], mem_read2_3};
    end
    p1_a[0] <= mem_addr2[9:4];
    p3_a[0] <= mem_addr2_3[9:4];
    for (int k = 1; k < 8; k++) begin
      p1_a[k] <= p1_a[k-1];
      p3_a[k] <= p3_a[k-1];
    end
  end

  logic [127:0] rd1, rd3;
  assign rd1 = p1_v[LAT1-1] ? mem[p1_a[LAT1-1]] : {4{32'hBAD0_F00D}};
  assign rd3 = p3_v[LAT3-1] ? mem[p3_a[LAT3-1]] : {4{32'hBAD0_F00D}};
  assign {mem_r3, mem_r2, mem_r1, mem_r0}         = rd1;
  assign {mem_r3_3, mem_r2_3, mem_r1_3, mem_r0_3} = rd3;

  // ------------------------------------------------------------------------
  // Helpers
  // ------------------------------------------------------------------------
  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IC fill on dut1; returns cycles from request to ACK (0 = no ACK).
  task automatic fill_ic(input logic [31:0] addr, output int lat);
    ic_addr = addr;
    ic_req  = 1'b1;
    lat     = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ic_ack) begin
        lat    = i;
        ic_req = 1'b0;
        break;
      end
    end
    ic_req = 1'b0;
    $display("txn IC fill addr=%h lat=%0d err=%0b line=%h", addr, lat, ic_err, ic_line);
  endtask

  // Both requesters fill at once; reports which side was acknowledged first.
  task automatic serve_both(input string tag, output logic first_dc);
    logic got_ic, got_dc;
    int   reads;
    got_ic = 1'b0; got_dc = 1'b0; reads = 0; first_dc = 1'b0;
    ic_addr = 32'h0000_0100; dc_addr = 32'h0000_0200; dc_we = 1'b0;
    ic_req  = 1'b1;          dc_req  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_read2) reads++;
      if (ic_ack) begin
        if (!got_dc) first_dc = 1'b0;
        got_ic = 1'b1; ic_req = 1'b0;
        check({tag, "_ic_line"}, ic_line, LINE_100);
        $display("txn %s IC ack line=%h", tag, ic_line);
      end
      if (dc_ack) begin
        if (!got_ic) first_dc = 1'b1;
        got_dc = 1'b1; dc_req = 1'b0;
        check({tag, "_dc_line"}, dc_rline, LINE_200);
        $display("txn %s DC ack line=%h", tag, dc_rline);
      end
      if (got_ic && got_dc) break;
    end
    ic_req = 1'b0; dc_req = 1'b0;
    check({tag, "_both_acked"}, {126'd0, got_ic, got_dc}, 128'd3);
    check({tag, "_reads"}, 128'(reads), 128'd2);
  endtask

  // ------------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------------
  initial begin
    int          lat;
    logic        first_dc;
    logic        exp_first1, exp_first2;

    rst_n = 1'b0; mem_init = 1'b1;
    ic_req = 0; ic_addr = 0; dc_req = 0; dc_we = 0; dc_addr = 0; dc_wline = 0;
    ic_req3 = 0; ic_addr3 = 0; dc_req3 = 0; dc_we3 = 0; dc_addr3 = 0; dc_wline3 = 0;
    repeat (3) step();

    // Reset state
    check("rst_ic_ack",  128'(ic_ack), 128'd0);
    check("rst_dc_ack",  128'(dc_ack), 128'd0);
    check("rst_strobes", 128'({mem_read2, mem_write2, ic_err, dc_err}), 128'd0);
    check("rst_addr",    128'(mem_addr2), 128'd0);
    check("rst_lines",   ic_line | dc_rline, 128'd0);
    check("rst_wline",   128'({mem_w3, mem_w2, mem_w1, mem_w0}), 128'd0);
    mem_init = 1'b0; rst_n = 1'b1;
    step();

    // 1: IC fill of line 0x100, RD_LAT=1
    ic_addr = 32'h0000_0104; ic_req = 1'b1;
    step();
    check("t1_read2_c1",  128'(mem_read2), 128'd1);
    check("t1_addr_c1",   128'(mem_addr2), 128'h100);
    check("t1_write2_c1", 128'(mem_write2), 128'd0);
    step();
    check("t1_ack_c2",    128'(ic_ack), 128'd0);
    check("t1_read2_c2",  128'(mem_read2), 128'd0);
    step();
    check("t1_ack_c3",    128'(ic_ack), 128'd1);
    check("t1_err_c3",    128'(ic_err), 128'd0);
    check("t1_line",      ic_line, LINE_100);
    $display("txn t1 IC fill line=%h", ic_line);
    ic_req = 1'b0;
    step();
    check("t1_ack_pulse", 128'(ic_ack), 128'd0);
    check("t1_addr_hold", 128'(mem_addr2), 128'h100);

    // 2: DC write-back to 0x200, then fill it back
    dc_we = 1'b1; dc_addr = 32'h0000_0200; dc_wline = LINE_200; dc_req = 1'b1;
    step();
    check("t2_write2_c1", 128'(mem_write2), 128'd1);
    check("t2_read2_c1",  128'(mem_read2), 128'd0);
    check("t2_w0",        128'(mem_w0), 128'hAAAA_0001);
    check("t2_w3",        128'(mem_w3), 128'hDDDD_0004);
    check("t2_wline",     {mem_w3, mem_w2, mem_w1, mem_w0}, LINE_200);
    check("t2_addr_c1",   128'(mem_addr2), 128'h200);
    step();
    check("t2_ack_c2",    128'(dc_ack), 128'd1);
    check("t2_err_c2",    128'(dc_err), 128'd0);
    check("t2_write2_c2", 128'(mem_write2), 128'd0);
    $display("txn t2 DC write-back addr=200");
    dc_req = 1'b0; dc_we = 1'b0; dc_wline = '0;
    step();
    dc_addr = 32'h0000_0208; dc_req = 1'b1;
    step();
    check("t2f_read2_c1", 128'(mem_read2), 128'd1);
    step();
    check("t2f_ack_c2",   128'(dc_ack), 128'd0);
    step();
    check("t2f_ack_c3",   128'(dc_ack), 128'd1);
    check("t2f_line",     dc_rline, LINE_200);
    check("t2f_ic_hold",  ic_line, LINE_100);
    $display("txn t2 DC fill line=%h", dc_rline);
    dc_req = 1'b0;
    step();

    // 3: ties
`ifdef OTTER_ARB_RR_EN
    exp_first1 = 1'b0; exp_first2 = 1'b1;
`else
    exp_first1 = 1'b1; exp_first2 = 1'b1;
`endif
    serve_both("tie1", first_dc);
    check("tie1_first_dc", 128'(first_dc), 128'(exp_first1));
    step();
    fill_ic(32'h0000_0100, lat);
    check("solo_lat", 128'(lat), 128'd3);
    step();
    serve_both("tie2", first_dc);
    check("tie2_first_dc", 128'(first_dc), 128'(exp_first2));
    step();

    // 4: out-of-range requests
    dc_we = 1'b1; dc_addr = 32'h1100_0000; dc_wline = '1; dc_req = 1'b1;
    step();
    check("t4_dc_ack",    128'({dc_ack, dc_err}), 128'd3);
    check("t4_dc_strobe", 128'({mem_read2, mem_write2}), 128'd0);
    $display("txn t4 DC err addr=%h", dc_addr);
    dc_req = 1'b0; dc_we = 1'b0;
    step();
    check("t4_dc_pulse",  128'({dc_ack, dc_err, mem_write2, mem_read2}), 128'd0);
    ic_addr = 32'h0001_0000; ic_req = 1'b1;
    step();
    check("t4_ic_ack",    128'({ic_ack, ic_err}), 128'd3);
    check("t4_ic_strobe", 128'({mem_read2, mem_write2}), 128'd0);
    $display("txn t4 IC err addr=%h", ic_addr);
    ic_req = 1'b0;
    step();
    check("t4_ic_pulse",  128'({ic_ack, ic_err, mem_read2}), 128'd0);
    check("t4_addr_hold", 128'(mem_addr2), 128'h100);
    fill_ic(32'h0000_FFF0, lat);
    check("t4_edge_lat",  128'(lat), 128'd3);
    check("t4_edge_err",  128'(ic_err), 128'd0);
    check("t4_edge_addr", 128'(mem_addr2), 128'hFFF0);
    step();

    // 5: reset during WAIT of a fill
    ic_addr = 32'h0000_0100; ic_req = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("t5_ack",      128'(ic_ack), 128'd0);
    check("t5_strobes",  128'({mem_read2, mem_write2}), 128'd0);
    check("t5_outputs",  128'(mem_addr2) | ic_line | dc_rline, 128'd0);
    ic_req = 1'b0; rst_n = 1'b1;
    step();
    check("t5_no_ack",   128'(ic_ack), 128'd0);
    fill_ic(32'h0000_0100, lat);
    check("t5_new_lat",  128'(lat), 128'd3);
    check("t5_new_line", ic_line, LINE_100);
    step();

    // 6: RD_LAT=3 on dut3
    ic_addr3 = 32'h0000_0104; ic_req3 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) check("t6_read2_c1", 128'(mem_read2_3), 128'd1);
      if (c == 5) begin
        check("t6_ack_c5",  128'(ic_ack3), 128'd1);
        check("t6_line",    ic_line3, LINE_100);
        $display("txn t6 IC fill lat3 line=%h", ic_line3);
        ic_req3 = 1'b0;
      end else begin
        check($sformatf("t6_ack_c%0d", c), 128'(ic_ack3), 128'd0);
      end
    end
    step();
    check("t6_ack_pulse", 128'(ic_ack3), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
